fft_input_loader: RTL and testbench

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

---
 rtl/fft_input_loader_if.sv | 20 ++
 rtl/fft_input_loader.sv | 58 +++++
 tb/tb_fft_input_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: sample stream in, assembled 32-sample frame out, plus frame error pulse.
// The master modport is the producer/consumer side; the slave modport is the loader side.
interface fft_input_loader_if;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [2047:0] out_frame;
    logic          out_valid;
    logic          out_ready;
    logic          frame_err;
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_frame, out_valid, frame_err
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_frame, out_valid, frame_err
    );
endinterface

// File: rtl/fft_input_loader.sv
// fft_input_loader: ping-pong loader assembling 32 complex samples into a frame for FFT stage 0.
// Define FFT_INPUT_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_input_loader (
    input logic               clk,
    input logic               reset,
    fft_input_loader_if.slave bus
);
    logic [2047:0] r_bank [2];
    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [4:0]    r_wr_idx;
    logic          r_frame_err;
    logic [4:0]    w_addr;
    logic [1:0]    w_full_nxt;
    logic          w_xfer;
    logic          w_release;
    logic          w_last_slot;
    logic          w_commit;
`ifdef FFT_INPUT_LOADER_BITREV_EN
    assign w_addr = {r_wr_idx[0], r_wr_idx[1], r_wr_idx[2], r_wr_idx[3], r_wr_idx[4]};
`else
    assign w_addr = r_wr_idx;
`endif
    assign bus.in_ready  = ~r_full[r_wr_bank];
    assign bus.out_valid = r_full[r_rd_bank];
    assign bus.out_frame = r_full[r_rd_bank] ? r_bank[r_rd_bank] : '0;
    assign bus.frame_err = r_frame_err;
    assign w_xfer        = bus.in_valid & ~r_full[r_wr_bank];
    assign w_release     = r_full[r_rd_bank] & bus.out_ready;
    assign w_last_slot   = r_wr_idx == 5'd31;
    assign w_commit      = w_xfer & w_last_slot;
    // Commit and release always target different banks, so both updates apply together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_commit) w_full_nxt[r_wr_bank] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset && w_xfer) r_bank[r_wr_bank][{w_addr, 6'd0} +: 64] <= bus.in_data;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= 5'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_frame_err <= w_xfer & (bus.in_last ^ w_last_slot);
            if (w_release) r_rd_bank <= ~r_rd_bank;
            if (w_commit) r_wr_bank <= ~r_wr_bank;
            // A short frame restarts at slot 0; a full frame wraps naturally from 31.
            if (w_xfer) r_wr_idx <= (bus.in_last & ~w_last_slot) ? 5'd0 : r_wr_idx + 5'd1;
        end
    end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed scenario tests for fft_input_loader (natural or bit-reversed order).
module tb_fft_input_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    fft_input_loader_if bus ();
    fft_input_loader dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.frame_err === 1'b1) pulses++;

    function automatic logic [31:0] fl(input int i);
        int e = 0;
        if (i == 0) return 32'd0;
        while ((i >> (e + 1)) != 0) e++;
        return {1'b0, 8'(e + 127), 23'((i << (23 - e)) & 32'h7fffff)};
    endfunction

    function automatic int slot(input int i);
        logic [4:0] v = 5'(i);
`ifdef FFT_INPUT_LOADER_BITREV_EN
        return int'({v[0], v[1], v[2], v[3], v[4]});
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [63:0] smp(input int tag, input int i);
        return {fl(i), 32'(tag)};
    endfunction

    function automatic logic [2047:0] mk_frame(input int tag);
        logic [2047:0] f = '0;
        for (int i = 0; i < 32; i++) f[slot(i)*64 +: 64] = smp(tag, i);
        return f;
    endfunction

    function automatic int diff_slot(input logic [2047:0] a, input logic [2047:0] b);
        for (int k = 0; k < 32; k++) if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
        return 0;
    endfunction

    task automatic send(input logic [63:0] d, input logic last, input logic rel);
        int n = 0;
        @(negedge clk);
        bus.in_data = d;
        bus.in_last = last;
        bus.in_valid = 1'b1;
        bus.out_ready = rel;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic send_frame(input int tag, input int n, input logic last_on_end);
        for (int i = 0; i < n; i++) send(smp(tag, i), last_on_end && i == n - 1, 1'b0);
    endtask

    task automatic release_frame();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
        checks++;
        if (bus.out_frame !== '0) begin errors++; $display("FAIL reset_out_frame got nonzero slot %0d required 0", diff_slot(bus.out_frame, '0)); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b required 0", bus.frame_err); end
    endtask

    task automatic test_single_frame();
        logic [2047:0] f;
        send_frame(0, 32, 1'b1);
        @(negedge clk);
        f = bus.out_frame;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b required 1", bus.out_valid); end
`ifdef FFT_INPUT_LOADER_BITREV_EN
        checks++;
        if (f[16*64 +: 64] !== 64'h3f800000_00000000) begin errors++; $display("FAIL single_slot16 got %h required 3f80000000000000", f[16*64 +: 64]); end
        checks++;
        if (f[1*64 +: 64] !== 64'h41800000_00000000) begin errors++; $display("FAIL single_slot1 got %h required 4180000000000000", f[1*64 +: 64]); end
`else
        checks++;
        if (f[1*64 +: 64] !== 64'h3f800000_00000000) begin errors++; $display("FAIL single_slot1 got %h required 3f80000000000000", f[1*64 +: 64]); end
        checks++;
        if (f[16*64 +: 64] !== 64'h41800000_00000000) begin errors++; $display("FAIL single_slot16 got %h required 4180000000000000", f[16*64 +: 64]); end
`endif
        checks++;
        if (f !== mk_frame(0)) begin errors++; $display("FAIL single_frame slot %0d got %h required %h", diff_slot(f, mk_frame(0)), f[diff_slot(f, mk_frame(0))*64 +: 64], mk_frame(0)[diff_slot(f, mk_frame(0))*64 +: 64]); end
        release_frame();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_released got %b required 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int s;
        send_frame(1, 32, 1'b1);
        send_frame(2, 32, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full got %b required 0", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data = 64'hdeadbeef_deadbeef;
        bus.in_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_frame !== mk_frame(1) || bus.out_valid !== 1'b1) begin
                errors++;
                s = diff_slot(bus.out_frame, mk_frame(1));
                $display("FAIL b2b_hold cycle %0d valid=%b slot %0d got %h required %h", c, bus.out_valid, s, bus.out_frame[s*64 +: 64], mk_frame(1)[s*64 +: 64]);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        release_frame();
        @(negedge clk);
        s = diff_slot(bus.out_frame, mk_frame(2));
        checks++;
        if (bus.out_frame !== mk_frame(2)) begin errors++; $display("FAIL b2b_frame2 slot %0d got %h required %h", s, bus.out_frame[s*64 +: 64], mk_frame(2)[s*64 +: 64]); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after got %b required 1", bus.in_ready); end
        send_frame(3, 32, 1'b1);
        release_frame();
        @(negedge clk);
        s = diff_slot(bus.out_frame, mk_frame(3));
        checks++;
        if (bus.out_frame !== mk_frame(3) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_frame3 valid=%b slot %0d got %h required %h", bus.out_valid, s, bus.out_frame[s*64 +: 64], mk_frame(3)[s*64 +: 64]); end
        release_frame();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b required 0", bus.out_valid); end
    endtask

    task automatic test_frame_err();
        int p0;
        int s;
        p0 = pulses;
        send_frame(4, 10, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL short_err_pulse got %b required 1", bus.frame_err); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL short_no_valid got %b required 0", bus.out_valid); end
        send_frame(5, 32, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL short_err_count got %0d required 1", pulses - p0); end
        s = diff_slot(bus.out_frame, mk_frame(5));
        checks++;
        if (bus.out_frame !== mk_frame(5)) begin errors++; $display("FAIL short_frame slot %0d got %h required %h", s, bus.out_frame[s*64 +: 64], mk_frame(5)[s*64 +: 64]); end
        release_frame();
        p0 = pulses;
        send_frame(6, 32, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL nolast_err_pulse got %b required 1", bus.frame_err); end
        s = diff_slot(bus.out_frame, mk_frame(6));
        checks++;
        if (bus.out_frame !== mk_frame(6) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL nolast_frame valid=%b slot %0d got %h required %h", bus.out_valid, s, bus.out_frame[s*64 +: 64], mk_frame(6)[s*64 +: 64]); end
        @(negedge clk);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL nolast_err_count got %0d required 1", pulses - p0); end
        release_frame();
    endtask

    task automatic test_concurrent_reset();
        int s;
        send_frame(7, 32, 1'b1);
        send_frame(8, 31, 1'b0);
        send(smp(8, 31), 1'b1, 1'b1);
        @(negedge clk);
        s = diff_slot(bus.out_frame, mk_frame(8));
        checks++;
        if (bus.out_frame !== mk_frame(8) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL conc_frame valid=%b slot %0d got %h required %h", bus.out_valid, s, bus.out_frame[s*64 +: 64], mk_frame(8)[s*64 +: 64]); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL conc_in_ready got %b required 1", bus.in_ready); end
        send_frame(9, 15, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_frame !== '0) begin errors++; $display("FAIL rst_mid_out got valid=%b slot0=%h required 0", bus.out_valid, bus.out_frame[63:0]); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b required 1", bus.in_ready); end
        send_frame(10, 32, 1'b1);
        @(negedge clk);
        s = diff_slot(bus.out_frame, mk_frame(10));
        checks++;
        if (bus.out_frame !== mk_frame(10) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_next_frame valid=%b slot %0d got %h required %h", bus.out_valid, s, bus.out_frame[s*64 +: 64], mk_frame(10)[s*64 +: 64]); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_err();
        test_concurrent_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
